// File: rtl/io_uart_tx_fifo.sv
// rtl/io_uart_tx_fifo.sv - buffered 8N1 UART transmitter on the CPU IO bus; FIFO enabled by UART_TX_FIFO_EN
module io_uart_tx_fifo #(
   parameter int CLK_FREQ_HZ = 10000000,
   parameter int BAUD_RATE   = 1000000,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_wr,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   output logic        uart_tx,
   output logic        tx_busy,
   output logic        tx_empty_irq
);

   localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [7:0]    head;
   logic          baud_last;
   logic          pop;
   logic          push;
   logic          wr_data;
   logic          wr_status;
   logic          fifo_empty;
   logic          fifo_full;
   logic          status_full;
   logic          overflow;
   logic [31:0]   count32;
   logic [31:0]   status;
   logic          unused_ok;

   assign wr_data   = io_wr & io_addr[3];
   assign wr_status = io_wr & io_addr[4];
   assign push      = wr_data & ~fifo_full;
   assign baud_last = (baud_cnt == CW'(DIV - 1));

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] count;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign count       = wr_ptr - rd_ptr;
   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head        = mem[rd_ptr[AW-1:0]];
   assign status_full = fifo_full;
   assign count32     = 32'(count);

   // Advance read/write pointers on pop/push
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Byte storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= io_wdata[7:0];
   end
`else
   logic       hold_valid;
   logic [7:0] hold_data;

   // Depth-1 mode: the transmitter as a whole holds one byte, so a write is
   // refused while anything is pending or on the line (legacy !uart_ready)
   assign fifo_empty  = ~hold_valid;
   assign fifo_full   = tx_busy;
   assign head        = hold_data;
   assign status_full = tx_busy;
   assign count32     = {31'b0, hold_valid};

   // Holding register filled by a CPU write, drained by the FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_data  <= 8'h00;
      end else if (push) begin
         hold_valid <= 1'b1;
         hold_data  <= io_wdata[7:0];
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

   // Sticky overflow: a dropped write wins over a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         overflow <= 1'b0;
      else if (wr_data && fifo_full)
         overflow <= 1'b1;
      else if (wr_status && io_wdata[10])
         overflow <= 1'b0;
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next state and pop decision; STOP chains straight into START when data waits
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE:  if (!fifo_empty) begin
                   pop        = 1'b1;
                   state_next = START;
                end
         START: if (baud_last) state_next = DATA;
         DATA:  if (baud_last && bit_idx == 3'd7) state_next = STOP;
         STOP:  if (baud_last) begin
                   if (!fifo_empty) begin
                      pop        = 1'b1;
                      state_next = START;
                   end else begin
                      state_next = IDLE;
                   end
                end
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: line level per state, decoded from state so reset forces it high at once
   always_comb begin
      uart_tx = 1'b1;
      case (state)
         START:   uart_tx = 1'b0;
         DATA:    uart_tx = shift[0];
         default: uart_tx = 1'b1;
      endcase
   end

   // Baud counter restarts on every state entry and bit; shift register loads on pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shift    <= 8'h00;
      end else begin
         if (state == IDLE || state_next != state || baud_last)
            baud_cnt <= '0;
         else
            baud_cnt <= baud_cnt + CW'(1);

         if (state != DATA)
            bit_idx <= 3'd0;
         else if (baud_last)
            bit_idx <= bit_idx + 3'd1;

         if (pop)
            shift <= head;
         else if (state == DATA && baud_last)
            shift <= {1'b0, shift[7:1]};
      end
   end

   assign tx_busy      = ~fifo_empty | (state != IDLE);
   assign tx_empty_irq = fifo_empty & (state == IDLE);
   assign status       = {21'b0, overflow, status_full, 3'b0, count32[5:0]};
   assign io_rdata     = io_addr[4] ? status : 32'b0;

   assign unused_ok = ^{io_addr[31:5], io_addr[2:0], io_wdata[31:11], io_wdata[9:8], count32[31:6]};

endmodule

// File: tb/tb_io_uart_tx_fifo.sv
// tb/tb_io_uart_tx_fifo.sv - directed self-checking bench for io_uart_tx_fifo
module tb_io_uart_tx_fifo;

   localparam logic [31:0] A_DATA = 32'h0000_0008;
   localparam logic [31:0] A_STAT = 32'h0000_0010;
`ifdef UART_TX_FIFO_EN
   localparam logic [31:0] BUSY_BIT = 32'h0000_0000;
   localparam logic [31:0] G_PRE    = 32'h0000_0001;
`else
   localparam logic [31:0] BUSY_BIT = 32'h0000_0200;
   localparam logic [31:0] G_PRE    = 32'h0000_0600;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        io_wr;
   logic [31:0] io_addr;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata;
   logic        uart_tx;
   logic        tx_busy;
   logic        tx_empty_irq;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   logic [7:0] rxq[$];
   int         startq[$];

   io_uart_tx_fifo dut (
      .clk          (clk),
      .reset        (reset),
      .io_wr        (io_wr),
      .io_addr      (io_addr),
      .io_wdata     (io_wdata),
      .io_rdata     (io_rdata),
      .uart_tx      (uart_tx),
      .tx_busy      (tx_busy),
      .tx_empty_irq (tx_empty_irq)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      io_wr    = 1'b1;
      io_addr  = a;
      io_wdata = d;
      tick();
      io_wr    = 1'b0;
      io_addr  = 32'h0;
      io_wdata = 32'h0;
   endtask

   task automatic check_stat(input string tag, input logic [31:0] exp);
      logic [31:0] v;
      io_addr = A_STAT;
      #1;
      v = io_rdata;
      io_addr = 32'h0;
      check(tag, v, exp);
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (tx_busy === 1'b1 && n < max) begin
         tick();
         n++;
      end
      check("idle_wait", {31'b0, tx_busy}, 32'h0);
   endtask

   task automatic clear_rx();
      rxq.delete();
      startq.delete();
   endtask

   task automatic check_rx(input string tag, input logic [7:0] first, input int num);
      check({tag, "_n"}, rxq.size(), num);
      for (int i = 0; i < num && i < rxq.size(); i++) begin
         check({tag, "_byte"}, {24'b0, rxq[i]}, {24'b0, 8'(first + i)});
         if (i > 0) check({tag, "_gap"}, startq[i] - startq[i-1], 100);
      end
   endtask

   // Line monitor: detects a start bit, samples mid-bit, records byte and start cycle
   initial begin
      int         cnt;
      int         st;
      logic       act;
      logic [7:0] b;
      cnt = 0;
      st  = 0;
      act = 1'b0;
      b   = 8'h00;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            act = 1'b0;
         end else if (!act) begin
            if (uart_tx === 1'b0) begin
               act = 1'b1;
               cnt = 0;
               st  = cyc;
            end
         end else begin
            cnt++;
            if (cnt % 10 == 5) begin
               if (cnt / 10 == 0)
                  check("rx_start", {31'b0, uart_tx}, 32'h0);
               else if (cnt / 10 == 9)
                  check("rx_stop", {31'b0, uart_tx}, 32'h1);
               else
                  b[cnt/10 - 1] = uart_tx;
            end
            if (cnt == 99) begin
               rxq.push_back(b);
               startq.push_back(st);
               act = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] fr;

      reset    = 1'b1;
      io_wr    = 1'b0;
      io_addr  = 32'h0;
      io_wdata = 32'h0;
      #1;
      check("rst_tx", {31'b0, uart_tx}, 32'h1);
      check("rst_busy", {31'b0, tx_busy}, 32'h0);
      check("rst_irq", {31'b0, tx_empty_irq}, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_stat("rst_stat", 32'h0);
      io_addr = A_DATA;
      #1;
      check("rd_data_addr", io_rdata, 32'h0);
      io_addr = 32'h0;

      // Single byte 0x55: exact per-cycle line shape
      clear_rx();
      wr(A_DATA, 32'h55);
      check_stat("b_stat_push", BUSY_BIT | 32'h1);
      check("b_tx_pre", {31'b0, uart_tx}, 32'h1);
      check("b_busy", {31'b0, tx_busy}, 32'h1);
      check("b_irq", {31'b0, tx_empty_irq}, 32'h0);
      tick();
      fr = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 100; i++) begin
         check("b_line", {31'b0, uart_tx}, {31'b0, fr[i/10]});
         tick();
      end
      check("b_irq_end", {31'b0, tx_empty_irq}, 32'h1);
      check("b_busy_end", {31'b0, tx_busy}, 32'h0);
      check("b_tx_end", {31'b0, uart_tx}, 32'h1);
      check_stat("b_stat_end", 32'h0);
      check_rx("b_rx", 8'h55, 1);

`ifdef UART_TX_FIFO_EN
      // 16-byte burst: contiguous frames, busy drops 1601 cycles after first write
      begin
         int c1;
         clear_rx();
         for (int i = 0; i < 16; i++) wr(A_DATA, i);
         c1 = cyc - 15;
         wait_idle(2000);
         check("c_len", cyc - c1, 1601);
         check_rx("c_rx", 8'h00, 16);
      end

      // 18-byte burst: 17 accepted, 18th dropped with sticky overflow
      clear_rx();
      for (int i = 0; i < 17; i++) wr(A_DATA, 32'h40 + i);
      check_stat("d_full", 32'h210);
      wr(A_DATA, 32'h99);
      check_stat("d_ovf", 32'h610);
      wr(A_STAT, 32'h400);
      check_stat("d_clr", 32'h210);
      wait_idle(2000);
      check_rx("d_rx", 8'h40, 17);

      // Push and pop on the same edge at count 1
      clear_rx();
      wr(A_DATA, 32'h21);
      wr(A_DATA, 32'h22);
      check_stat("e_cnt", 32'h1);
      wait_idle(400);
      check_rx("e_rx", 8'h21, 2);
`else
      // Depth 1: a write during a frame is refused and flags overflow
      clear_rx();
      wr(A_DATA, 32'hA5);
      wr(A_DATA, 32'h33);
      check_stat("f_ovf", 32'h600);
      check("f_line", {31'b0, uart_tx}, 32'h0);
      wr(A_STAT, 32'h400);
      check_stat("f_clr", 32'h200);
      wait_idle(400);
      check_stat("f_idle", 32'h0);
      check_rx("f_rx", 8'hA5, 1);
`endif

      // Reset mid-DATA on 0xA5, then a clean frame after release
      clear_rx();
      wr(A_DATA, 32'hA5);
      wr(A_DATA, 32'h77);
      check_stat("g_pre", G_PRE);
      repeat (40) tick();
      check("g_mid_line", {31'b0, uart_tx}, 32'h0);
      reset = 1'b1;
      #1;
      check("g_rst_tx", {31'b0, uart_tx}, 32'h1);
      check("g_rst_busy", {31'b0, tx_busy}, 32'h0);
      check("g_rst_irq", {31'b0, tx_empty_irq}, 32'h1);
      check_stat("g_rst_stat", 32'h0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("g_rel_tx", {31'b0, uart_tx}, 32'h1);
      clear_rx();
      wr(A_DATA, 32'h3C);
      wait_idle(400);
      check_rx("g_rx", 8'h3C, 1);
      check_stat("g_end", 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
